// File: rtl/inst_fetcher_if.sv
// ============================================================================
//  Module      : inst_fetcher_if
//  Description : Bundles the fetch unit's icache handshake and decoder-facing
//                signals. The master modport is the fetch unit; the slave
//                modport is the environment (icache, decoder, ROB, dispatch).
//  Signals     : _br_rob, _dispatch_full, _next_pc, _stall   -> fetcher
//                _icache_req, _icache_addr                   <- fetcher
//                _icache_ready, _icache_data                 -> fetcher
//                _inst_out, _inst_ready_out, _inst_addr_out  <- fetcher
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface inst_fetcher_if;
    logic        _br_rob;
    logic        _dispatch_full;
    logic        _icache_req;
    logic [31:0] _icache_addr;
    logic        _icache_ready;
    logic [31:0] _icache_data;
    logic [31:0] _inst_out;
    logic        _inst_ready_out;
    logic [31:0] _inst_addr_out;
    logic [31:0] _next_pc;
    logic        _stall;

    modport master (
        input  _br_rob, _dispatch_full, _icache_ready, _icache_data, _next_pc, _stall,
        output _icache_req, _icache_addr, _inst_out, _inst_ready_out, _inst_addr_out
    );

    modport slave (
        output _br_rob, _dispatch_full, _icache_ready, _icache_data, _next_pc, _stall,
        input  _icache_req, _icache_addr, _inst_out, _inst_ready_out, _inst_addr_out
    );
endinterface

`default_nettype wire

// File: rtl/inst_fetcher.sv
// ============================================================================
//  Module      : inst_fetcher
//  Description : Front-end fetch unit. Holds the fetch PC, fills a one-word
//                line buffer from the icache and assembles 16-bit (RVC) and
//                32-bit instructions, including 32-bit ones that straddle a
//                word boundary. Stalls after a JALR until the ROB redirects.
//  Ports       : clk_in  - system clock
//                rst_in  - synchronous reset, active high
//                rdy_in  - 0 freezes all state and suppresses issue
//                fif     - inst_fetcher_if.master (icache + decoder signals)
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module inst_fetcher #(
    parameter logic [31:0] RESET_PC   = 32'h0,
    parameter bit          ENABLE_RVC = 1'b1
) (
    input  wire logic      clk_in,
    input  wire logic      rst_in,
    input  wire logic      rdy_in,
    inst_fetcher_if.master fif
);

    typedef enum logic [1:0] {
        S_LOOK     = 2'd0,
        S_WAIT     = 2'd1,
        S_WAIT_ROB = 2'd2,
        S_DRAIN    = 2'd3
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_buf;
    logic [29:0] r_buf_addr;
    logic        r_buf_valid;
    logic [15:0] r_span_half;
    logic        r_span_valid;
    logic [31:0] r_span_pc;
    logic        r_req;
    logic [31:0] r_req_addr;

    logic [29:0] w_pc_word;
    logic [29:0] w_pc_word_nx;
    logic        w_span_hit_pc;
    logic [15:0] w_buf_half;
    logic [15:0] w_half;
    logic        w_rvc;
    logic        w_hit_cur;
    logic        w_hit_nxt;
    logic        w_avail;
    logic        w_capture;
    logic [29:0] w_miss_word;
    logic [31:0] w_inst;
    logic        w_issue;
    logic        w_take;

    assign w_pc_word     = r_pc[31:2];
    assign w_pc_word_nx  = r_pc[31:2] + 30'd1;
    assign w_span_hit_pc = r_span_valid && (r_span_pc == r_pc);
    assign w_buf_half    = r_pc[1] ? r_buf[31:16] : r_buf[15:0];
    // Once the low half of a straddling instruction is captured the buffer
    // is refilled with the following word, so the length must come from the
    // captured half, not from whatever the buffer now holds at pc[1].
    assign w_half        = w_span_hit_pc ? r_span_half : w_buf_half;
    assign w_rvc         = (ENABLE_RVC != 1'b0) && (w_half[1:0] != 2'b11);
    assign w_hit_cur     = r_buf_valid && (r_buf_addr == w_pc_word);
    assign w_hit_nxt     = r_buf_valid && (r_buf_addr == w_pc_word_nx);

    always_comb begin
        w_avail     = 1'b0;
        w_capture   = 1'b0;
        w_miss_word = w_pc_word;
        w_inst      = 32'h0;
        if (w_rvc) begin
            if (w_hit_cur) begin
                w_avail = 1'b1;
                w_inst  = {16'h0, w_half};
            end
        end else if (!r_pc[1]) begin
            if (w_hit_cur) begin
                w_avail = 1'b1;
                w_inst  = r_buf;
            end
        end else if (w_span_hit_pc) begin
            if (w_hit_nxt) begin
                w_avail = 1'b1;
                w_inst  = {r_buf[15:0], r_span_half};
            end else begin
                w_miss_word = w_pc_word_nx;
            end
        end else if (w_hit_cur) begin
            w_capture = 1'b1;
        end
    end

    // Issue depends only on registered state and on inputs that are not fed
    // back from the decoder, so there is no combinational loop via _next_pc.
    assign w_issue = !rst_in && rdy_in && (r_state == S_LOOK) && !fif._br_rob &&
                     !fif._dispatch_full && w_avail;

    // A response is accepted whenever one is owed, including after a redirect.
    assign w_take  = fif._icache_ready && ((r_state == S_WAIT) || (r_state == S_DRAIN));

    assign fif._inst_ready_out = w_issue;
    assign fif._inst_out       = w_issue ? w_inst : 32'h0;
    assign fif._inst_addr_out  = w_issue ? r_pc : 32'h0;
    assign fif._icache_req     = r_req;
    assign fif._icache_addr    = r_req_addr;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state      <= S_LOOK;
            r_pc         <= RESET_PC;
            r_buf        <= 32'h0;
            r_buf_addr   <= 30'h0;
            r_buf_valid  <= 1'b0;
            r_span_half  <= 16'h0;
            r_span_valid <= 1'b0;
            r_span_pc    <= 32'h0;
            r_req        <= 1'b0;
            r_req_addr   <= 32'h0;
        end else if (rdy_in) begin
            if (w_take) begin
                r_buf       <= fif._icache_data;
                r_buf_addr  <= r_req_addr[31:2];
                r_buf_valid <= 1'b1;
            end

            if (fif._br_rob) begin
                r_pc         <= fif._next_pc;
                r_span_valid <= 1'b0;
                r_req        <= 1'b0;
                if ((r_state == S_WAIT) && !fif._icache_ready) begin
                    r_state <= S_DRAIN;
                end else if ((r_state == S_DRAIN) && !fif._icache_ready) begin
                    r_state <= S_DRAIN;
                end else begin
                    r_state <= S_LOOK;
                end
            end else begin
                case (r_state)
                    S_LOOK: begin
                        if (w_avail) begin
                            if (!fif._dispatch_full) begin
                                r_span_valid <= 1'b0;
                                if (fif._stall) begin
                                    r_state <= S_WAIT_ROB;
                                end else begin
                                    r_pc <= fif._next_pc;
                                end
                            end
                        end else if (w_capture) begin
                            r_span_half  <= w_buf_half;
                            r_span_valid <= 1'b1;
                            r_span_pc    <= r_pc;
                            r_req        <= 1'b1;
                            r_req_addr   <= {w_pc_word_nx, 2'b00};
                            r_state      <= S_WAIT;
                        end else begin
                            r_req      <= 1'b1;
                            r_req_addr <= {w_miss_word, 2'b00};
                            r_state    <= S_WAIT;
                        end
                    end
                    S_WAIT: begin
                        if (fif._icache_ready) begin
                            r_req   <= 1'b0;
                            r_state <= S_LOOK;
                        end
                    end
                    S_DRAIN: begin
                        if (fif._icache_ready) begin
                            r_state <= S_LOOK;
                        end
                    end
                    default: begin
                        // S_WAIT_ROB: only a ROB redirect leaves this state.
                    end
                endcase
            end
        end
    end

endmodule

`default_nettype wire
